// File: rtl/cart_loader.sv
// cart_loader: streams ROM images from the ioctl download port into SDRAM slots,
// derives a power-of-two bank mask per slot and holds the core in reset around loads.
module cart_loader #(
  parameter int unsigned ADDR_W     = 22,
  parameter int unsigned N_SLOTS    = 2,
  parameter int unsigned BANK_SHIFT = 14,
  parameter int unsigned HOLD_CYC   = 1024
) (
  input  logic                              clk_sys,
  input  logic                              reset,
  input  logic                              ioctl_download,
  input  logic [7:0]                        ioctl_index,
  input  logic                              ioctl_wr,
  input  logic [24:0]                       ioctl_addr,
  input  logic [7:0]                        ioctl_dout,
  output logic                              ioctl_wait,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [7:0]                        mem_din,
  output logic                              mem_we,
  input  logic                              mem_ack,
  input  logic [$clog2(N_SLOTS)-1:0]        slot_sel,
  input  logic [ADDR_W-$clog2(N_SLOTS)-1:0] cpu_addr,
  output logic [ADDR_W-1:0]                 map_addr,
  output logic [N_SLOTS-1:0]                cart_valid,
  output logic                              core_reset,
  output logic                              err
);

  localparam int unsigned SLOT_W  = $clog2(N_SLOTS);
  localparam int unsigned SLOT_AW = ADDR_W - SLOT_W;
  localparam int unsigned BANK_W  = SLOT_AW - BANK_SHIFT;
  localparam int unsigned CNT_W   = $clog2(HOLD_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_FINISH,
    S_HOLD
  } state_t;

  state_t             state;
  logic               dl_prev;
  logic [SLOT_W-1:0]  slot;
  logic [SLOT_AW-1:0] max_addr;
  logic [CNT_W-1:0]   hold_cnt;
  logic [BANK_W-1:0]  mask [N_SLOTS];

  logic start;
  logic in_range;
  logic accept;
  logic drop;

  // Smear every bit below the MSB: rounds the highest bank number up to 2^n-1.
  function automatic logic [BANK_W-1:0] pow2_mask(input logic [BANK_W-1:0] b);
    logic [BANK_W-1:0] m;
    m = b;
    for (int i = 1; i < int'(BANK_W); i++) begin
      m = m | (b >> i);
    end
    return m;
  endfunction

  // Download start, range check and write-buffer acceptance/drop decisions.
  assign start    = ioctl_download && !dl_prev && (ioctl_index < 8'(N_SLOTS));
  assign in_range = (ioctl_addr[24:SLOT_AW] == '0);
  assign accept   = (state == S_LOAD) && ioctl_wr && !mem_we && in_range;
  assign drop     = (state == S_LOAD) && ioctl_wr && (mem_we || !in_range);

  // Load FSM, one-entry write buffer, mask/valid bookkeeping and core reset hold.
  always_ff @(posedge clk_sys) begin
    dl_prev <= ioctl_download;
    if (reset) begin
      state      <= S_IDLE;
      slot       <= '0;
      max_addr   <= '0;
      hold_cnt   <= CNT_W'(HOLD_CYC);
      mem_we     <= 1'b0;
      ioctl_wait <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      cart_valid <= '0;
      core_reset <= 1'b1;
      err        <= 1'b0;
      for (int k = 0; k < int'(N_SLOTS); k++) begin
        mask[k] <= '0;
      end
    end else begin
      core_reset <= (state != S_IDLE);

      if (mem_we && mem_ack) begin
        mem_we     <= 1'b0;
        ioctl_wait <= 1'b0;
      end

      if (accept) begin
        mem_we     <= 1'b1;
        ioctl_wait <= 1'b1;
        mem_addr   <= {slot, ioctl_addr[SLOT_AW-1:0]};
        mem_din    <= ioctl_dout;
        if (ioctl_addr[SLOT_AW-1:0] > max_addr) begin
          max_addr <= ioctl_addr[SLOT_AW-1:0];
        end
      end

      if (drop) begin
        err <= 1'b1;
      end

      if (start && (state == S_IDLE || state == S_HOLD)) begin
        slot     <= ioctl_index[SLOT_W-1:0];
        max_addr <= '0;
        cart_valid[ioctl_index[SLOT_W-1:0]] <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (start) state <= S_LOAD;
        end
        S_LOAD: begin
          if (!ioctl_download) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!mem_we) state <= S_FINISH;
        end
        S_FINISH: begin
          mask[slot]       <= pow2_mask(max_addr[SLOT_AW-1:BANK_SHIFT]);
          cart_valid[slot] <= 1'b1;
          hold_cnt         <= CNT_W'(HOLD_CYC);
          state            <= S_HOLD;
        end
        S_HOLD: begin
          if (start) begin
            state <= S_LOAD;
          end else if (hold_cnt <= CNT_W'(1)) begin
            state <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered CPU ROM address translation through the selected slot's bank mask.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      map_addr <= '0;
    end else begin
      map_addr <= {slot_sel,
                   cpu_addr[SLOT_AW-1:BANK_SHIFT] & mask[slot_sel],
                   cpu_addr[BANK_SHIFT-1:0]};
    end
  end

endmodule

// File: tb/tb_cart_loader.sv
// tb_cart_loader: directed + randomized checks of cart_loader against a simple
// transaction-level model (expected write list, max address, mask from pow2 arithmetic).
module tb_cart_loader;

  localparam int unsigned ADDR_W     = 22;
  localparam int unsigned SLOT_AW    = 21;
  localparam int unsigned BANK_SHIFT = 14;
  localparam int unsigned HOLD       = 1024;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [21:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        mem_ack;
  logic        slot_sel;
  logic [20:0] cpu_addr;
  logic [21:0] map_addr;
  logic [1:0]  cart_valid;
  logic        core_reset;
  logic        err;

  int checks = 0;
  int errors = 0;
  int ack_lat = 0;

  logic [29:0] exp_q[$];
  logic [29:0] got_q[$];
  int unsigned exp_mask [2];
  logic [1:0]  exp_valid;
  logic        exp_err;
  bit          model_active;
  int unsigned cur_slot;
  int unsigned max_a;

  cart_loader #(
    .ADDR_W(ADDR_W), .N_SLOTS(2), .BANK_SHIFT(BANK_SHIFT), .HOLD_CYC(HOLD)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_we(mem_we), .mem_ack(mem_ack), .slot_sel(slot_sel),
    .cpu_addr(cpu_addr), .map_addr(map_addr), .cart_valid(cart_valid),
    .core_reset(core_reset), .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  // SDRAM responder: acknowledge a pending write after ack_lat extra cycles.
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    mem_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (mem_we !== 1'b1) begin
        mem_ack = 1'b0;
        wait_cnt = 0;
      end else if (mem_ack !== 1'b1) begin
        if (wait_cnt >= ack_lat) mem_ack = 1'b1;
        else wait_cnt++;
      end
    end
  end

  // Record every write the SDRAM accepts.
  initial begin
    forever begin
      @(posedge clk_sys);
      if (mem_we === 1'b1 && mem_ack === 1'b1) got_q.push_back({mem_addr, mem_din});
    end
  end

  // Absolute time limit.
  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned mask_of(input int unsigned maxa);
    int unsigned b;
    int unsigned p;
    b = maxa >> BANK_SHIFT;
    p = 1;
    while (p <= b) p = p * 2;
    return p - 1;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (ioctl_wait !== 1'b0 && n < 1000) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 1000) check("ioctl_wait_timeout", 64'(ioctl_wait), 64'd0);
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    wait_idle();
    ioctl_wr = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (model_active && a < 25'(1 << SLOT_AW)) begin
      exp_q.push_back({22'(cur_slot * (1 << SLOT_AW) + int'(a)), d});
      if (int'(a) > int'(max_a)) max_a = int'(a);
    end
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input int unsigned idx);
    ioctl_index = 8'(idx);
    ioctl_download = 1'b1;
    if (idx < 2) begin
      model_active = 1'b1;
      cur_slot = idx;
      max_a = 0;
      exp_valid[idx] = 1'b0;
    end
    @(negedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic end_dl(input bit wait_hold);
    int n;
    wait_idle();
    ioctl_download = 1'b0;
    if (model_active) begin
      exp_valid[cur_slot] = 1'b1;
      exp_mask[cur_slot] = mask_of(max_a);
      model_active = 1'b0;
    end
    if (wait_hold) begin
      @(posedge clk_sys);
      n = 0;
      do begin
        @(posedge clk_sys);
        n++;
        #1;
      end while (core_reset !== 1'b0 && n < int'(HOLD) + 50);
      check("core_reset_release_cycles", 64'(n), 64'(HOLD + 3));
    end
    @(negedge clk_sys);
  endtask

  task automatic check_writes();
    check("write_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check("write_addr_data", 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic check_map(input int unsigned s, input int unsigned cpu);
    int unsigned e;
    slot_sel = 1'(s);
    cpu_addr = 21'(cpu);
    e = s * (1 << SLOT_AW) + ((cpu >> BANK_SHIFT) & exp_mask[s]) * (1 << BANK_SHIFT)
        + (cpu % (1 << BANK_SHIFT));
    @(negedge clk_sys);
    check("map_addr", 64'(map_addr), 64'(e));
  endtask

  initial begin
    reset = 1'b1;
    ioctl_download = 1'b0;
    ioctl_index = '0;
    ioctl_wr = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    slot_sel = 1'b0;
    cpu_addr = '0;
    exp_mask[0] = 0;
    exp_mask[1] = 0;
    exp_valid = '0;
    exp_err = 1'b0;
    model_active = 1'b0;
    cur_slot = 0;
    max_a = 0;
    repeat (3) @(negedge clk_sys);

    // Reset state
    check("rst_ioctl_wait", 64'(ioctl_wait), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_din", 64'(mem_din), 64'd0);
    check("rst_cart_valid", 64'(cart_valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_core_reset", 64'(core_reset), 64'd1);
    check("rst_map_addr", 64'(map_addr), 64'd0);
    reset = 1'b0;
    check_map(0, 'h1FFFFF);
    check("idle_core_reset", 64'(core_reset), 64'd0);

    // 48 KB image into slot 0 (sparse addresses, top byte included)
    ack_lat = 0;
    start_dl(0);
    check("load_core_reset", 64'(core_reset), 64'd1);
    send_byte(25'h0, 8'($urandom));
    for (int i = 0; i < 40; i++) send_byte(25'($urandom_range(0, 'hBFFE)), 8'($urandom));
    send_byte(25'hBFFF, 8'($urandom));
    end_dl(1'b1);
    check_writes();
    check("cart_valid_s0", 64'(cart_valid), 64'(exp_valid));
    check_map(0, 'h1C123);
    check("err_clean", 64'(err), 64'(exp_err));

    // 8 KB image into slot 1
    ack_lat = 2;
    start_dl(1);
    for (int i = 0; i < 30; i++) send_byte(25'($urandom_range(0, 'h1FFE)), 8'($urandom));
    send_byte(25'h1FFF, 8'($urandom));
    end_dl(1'b1);
    check_writes();
    check("cart_valid_s1", 64'(cart_valid), 64'(exp_valid));
    check_map(1, 'h4010);
    check_map(0, 'h1C123);

    // Out-of-range index: ignored entirely
    ack_lat = 0;
    start_dl(5);
    for (int i = 0; i < 4; i++) send_byte(25'(i), 8'($urandom));
    check("bad_index_mem_we", 64'(mem_we), 64'd0);
    check("bad_index_core_reset", 64'(core_reset), 64'd0);
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check_writes();
    check("bad_index_cart_valid", 64'(cart_valid), 64'(exp_valid));
    check("bad_index_err", 64'(err), 64'(exp_err));

    // Overrun and out-of-range drops with a slow SDRAM
    ack_lat = 20;
    start_dl(0);
    send_byte(25'h100, 8'h5A);
    check("busy_ioctl_wait", 64'(ioctl_wait), 64'd1);
    ioctl_wr = 1'b1;
    ioctl_addr = 25'h101;
    ioctl_dout = 8'hA5;
    exp_err = 1'b1;
    @(negedge clk_sys);
    ioctl_wr = 1'b0;
    check("err_overrun", 64'(err), 64'(exp_err));
    send_byte(25'h200000, 8'h33);
    send_byte(25'h20, 8'($urandom));
    end_dl(1'b0);
    check_writes();
    repeat (20) @(negedge clk_sys);
    check("hold_core_reset", 64'(core_reset), 64'd1);

    // New download during hold; zero-byte image
    start_dl(0);
    check("reload_clears_valid", 64'(cart_valid), 64'(exp_valid));
    end_dl(1'b1);
    check_writes();
    check("empty_cart_valid", 64'(cart_valid), 64'(exp_valid));
    check_map(0, 'h1C123);
    check("err_sticky", 64'(err), 64'(exp_err));

    // Random full-range image into slot 1, then random translations
    ack_lat = 1;
    start_dl(1);
    for (int i = 0; i < 12; i++)
      send_byte(25'($urandom_range(0, (1 << SLOT_AW) - 1)), 8'($urandom));
    end_dl(1'b1);
    check_writes();
    for (int i = 0; i < 8; i++)
      check_map($urandom_range(0, 1), $urandom_range(0, (1 << SLOT_AW) - 1));

    // Reset in the middle of a load with a write pending
    ack_lat = 1000;
    start_dl(1);
    send_byte(25'h10, 8'hAA);
    check("pending_mem_we", 64'(mem_we), 64'd1);
    reset = 1'b1;
    void'(exp_q.pop_back());
    exp_valid = '0;
    exp_err = 1'b0;
    exp_mask[0] = 0;
    exp_mask[1] = 0;
    model_active = 1'b0;
    @(negedge clk_sys);
    check("midreset_mem_we", 64'(mem_we), 64'd0);
    check("midreset_cart_valid", 64'(cart_valid), 64'(exp_valid));
    check("midreset_err", 64'(err), 64'(exp_err));
    ioctl_download = 1'b0;
    ack_lat = 0;
    reset = 1'b0;
    @(negedge clk_sys);
    check_writes();
    check_map(1, 'h1FFFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
